// File: rtl/pipeline_adder_arbiter.sv
// rtl/pipeline_adder_arbiter.sv - round-robin arbiter sharing one external pipelined adder among NREQ requesters
// Tag pipeline tracks which requester owns each in-flight add so results route back in grant order.
module pipeline_adder_arbiter #(
  parameter int WIDTH   = 64,
  parameter int NREQ    = 4,
  parameter int LATENCY = 2,
  parameter int MAX_OUT = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  input  logic [NREQ-1:0]         req_cin,
  output logic [NREQ-1:0]         req_ready,
  output logic [WIDTH-1:0]        add_a,
  output logic [WIDTH-1:0]        add_b,
  output logic                    add_cin,
  input  logic [WIDTH-1:0]        add_sum,
  input  logic                    add_cout,
  output logic [NREQ-1:0]         rsp_valid,
  output logic [WIDTH-1:0]        rsp_sum,
  output logic                    rsp_cout,
  output logic                    idle
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(MAX_OUT + 1);

  logic [IW-1:0]      ptr;
  logic [CW-1:0]      outstanding [NREQ];
  logic [LATENCY-1:0] tag_v;
  logic [IW-1:0]      tag_idx [LATENCY];
  logic [NREQ-1:0]    eligible;
  logic               grant_any;
  logic [IW-1:0]      grant_idx;
  logic               busy;

  // Eligibility uses the registered count only; a response this cycle frees nothing until next edge.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NREQ; i++) begin
      eligible[i] = req_valid[i] && (outstanding[i] < CW'(MAX_OUT));
    end
  end

  always_comb begin
    int idx;
    idx       = 0;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!rst && !grant_any && eligible[idx]) begin
        grant_any = 1'b1;
        grant_idx = IW'(idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (grant_any) req_ready[grant_idx] = 1'b1;
  end

  assign add_a   = grant_any ? req_a[grant_idx*WIDTH +: WIDTH] : '0;
  assign add_b   = grant_any ? req_b[grant_idx*WIDTH +: WIDTH] : '0;
  assign add_cin = grant_any & req_cin[grant_idx];

  always_comb begin
    rsp_valid = '0;
    if (tag_v[LATENCY-1]) rsp_valid[tag_idx[LATENCY-1]] = 1'b1;
  end

  assign rsp_sum  = tag_v[LATENCY-1] ? add_sum : '0;
  assign rsp_cout = tag_v[LATENCY-1] & add_cout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr   <= '0;
      tag_v <= '0;
      for (int s = 0; s < LATENCY; s++) tag_idx[s] <= '0;
    end else begin
      tag_v[0]   <= grant_any;
      tag_idx[0] <= grant_idx;
      for (int s = 1; s < LATENCY; s++) begin
        tag_v[s]   <= tag_v[s-1];
        tag_idx[s] <= tag_idx[s-1];
      end
      if (grant_any) ptr <= (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + IW'(1);
    end
  end

  // Grant and response to the same requester in one cycle cancel out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREQ; i++) outstanding[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_ready[i] && !rsp_valid[i])      outstanding[i] <= outstanding[i] + CW'(1);
        else if (!req_ready[i] && rsp_valid[i]) outstanding[i] <= outstanding[i] - CW'(1);
      end
    end
  end

  always_comb begin
    busy = |tag_v;
    for (int i = 0; i < NREQ; i++) busy = busy | (outstanding[i] != '0);
  end

  assign idle = !busy;

endmodule

// File: tb/tb_pipeline_adder_arbiter.sv
// tb/tb_pipeline_adder_arbiter.sv - scoreboard bench for pipeline_adder_arbiter with a modelled external adder
module tb_pipeline_adder_arbiter;
  localparam int W = 64;
  localparam int N = 4;
  localparam int L = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_a, req_b;
  logic [N-1:0]   req_cin;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   add_a, add_b, add_sum;
  logic           add_cin, add_cout;
  logic [N-1:0]   rsp_valid;
  logic [W-1:0]   rsp_sum;
  logic           rsp_cout;
  logic           idle;

  pipeline_adder_arbiter #(.WIDTH(W), .NREQ(N), .LATENCY(L), .MAX_OUT(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_cin(req_cin), .req_ready(req_ready), .add_a(add_a), .add_b(add_b),
    .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout), .rsp_valid(rsp_valid),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .idle(idle)
  );

  always #5 clk = ~clk;

  logic [W:0] pipe [L];
  always @(posedge clk) begin
    pipe[0] <= {1'b0, add_a} + {1'b0, add_b} + (W+1)'(add_cin);
    for (int s = 1; s < L; s++) pipe[s] <= pipe[s-1];
  end
  assign add_sum  = pipe[L-1][W-1:0];
  assign add_cout = pipe[L-1][W];

  typedef struct {
    int         idx;
    logic [W-1:0] sum;
    logic       cout;
    int         due;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_mon;
  int n_vec = 0;
  int n_fail = 0;
  int cyc = 0;

  logic [W-1:0] ta [N];
  logic [W-1:0] tb [N];
  logic         tc [N];
  logic [W-1:0] ts [N];
  logic         tco [N];
  logic [N-1:0] exp_g;
  logic [W:0]   rsum;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input bit ok, input string name, input logic [W:0] act, input logic [W:0] req);
    n_vec++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  function automatic void push(input int i, input logic [W-1:0] s, input logic c);
    exp_t e;
    e.idx = i; e.sum = s; e.cout = c; e.due = cyc + L;
    exp_q.push_back(e);
  endfunction

  always @(negedge clk) begin
    if (rsp_valid != '0) begin
      if (exp_q.size() == 0) begin
        chk(1'b0, "unexpected_rsp", (W+1)'(rsp_valid), '0);
      end else begin
        e_mon = exp_q.pop_front();
        chk(rsp_valid == (N'(1) << e_mon.idx), "rsp_valid", (W+1)'(rsp_valid), (W+1)'(N'(1) << e_mon.idx));
        chk({rsp_cout, rsp_sum} == {e_mon.cout, e_mon.sum}, "rsp_data", {rsp_cout, rsp_sum}, {e_mon.cout, e_mon.sum});
        chk(cyc == e_mon.due, "rsp_latency", (W+1)'(cyc), (W+1)'(e_mon.due));
      end
    end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      e_mon = exp_q.pop_front();
      chk(1'b0, "missing_rsp", '0, (W+1)'(N'(1) << e_mon.idx));
    end
  end

  task automatic set_req(input logic [N-1:0] v);
    req_valid = v;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = ta[i];
      req_b[i*W +: W] = tb[i];
      req_cin[i]      = tc[i];
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    req_valid = '0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && !(exp_q.size() == 0 && idle); k++) @(negedge clk);
    chk(exp_q.size() == 0 && idle === 1'b1, "drain_idle", (W+1)'({exp_q.size() == 0, idle}), (W+1)'(2'b11));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    ta[0] = 64'hFFFF_FFFF_FFFF_FFFF; tb[0] = 64'h1;                   tc[0] = 1'b0;
    ts[0] = 64'h0;                   tco[0] = 1'b1;
    ta[1] = 64'h8000_0000_0000_0000; tb[1] = 64'h8000_0000_0000_0000; tc[1] = 1'b1;
    ts[1] = 64'h1;                   tco[1] = 1'b1;
    ta[2] = 64'h1234_5678_9ABC_DEF0; tb[2] = 64'h0FED_CBA9_8765_4321; tc[2] = 1'b0;
    ts[2] = 64'h2222_2222_2222_2211; tco[2] = 1'b0;
    ta[3] = 64'hFFFF_FFFF_FFFF_FFFF; tb[3] = 64'hFFFF_FFFF_FFFF_FFFF; tc[3] = 1'b1;
    ts[3] = 64'hFFFF_FFFF_FFFF_FFFF; tco[3] = 1'b1;

    rst = 1'b1;
    set_req('1);
    @(negedge clk);
    chk(rsp_valid == '0, "reset_rsp_valid", (W+1)'(rsp_valid), '0);
    chk(idle == 1'b1, "reset_idle", (W+1)'(idle), 1);
    chk(req_ready == '0, "reset_ready", (W+1)'(req_ready), '0);

    // Single operation on requester 0
    @(posedge clk); #1;
    rst = 1'b0;
    set_req(4'b0001);
    @(negedge clk);
    chk(req_ready == 4'b0001, "single_grant", (W+1)'(req_ready), 1);
    chk({add_cin, add_a, add_b} == {tc[0], ta[0], tb[0]}, "add_operands", {add_cin, add_a}, {tc[0], ta[0]});
    push(0, ts[0], tco[0]);
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    chk(add_a == '0 && add_b == '0 && add_cin == 1'b0, "idle_operands", (W+1)'(add_a | add_b), '0);
    drain();

    // All requesters valid: round-robin one grant per cycle
    do_reset();
    set_req(4'b1111);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      exp_g = N'(1) << (c % N);
      chk(req_ready == exp_g, "rr_grant", (W+1)'(req_ready), (W+1)'(exp_g));
      push(c % N, ts[c % N], tco[c % N]);
      @(posedge clk); #1;
    end
    req_valid = '0;
    drain();

    // Single requester limited by MAX_OUT: grant, grant, blocked
    do_reset();
    set_req(4'b0100);
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      exp_g = (c % 3 != 2) ? 4'b0100 : 4'b0000;
      chk(req_ready == exp_g, "maxout_grant", (W+1)'(req_ready), (W+1)'(exp_g));
      if (c % 3 != 2) push(2, ts[2], tco[2]);
      @(posedge clk); #1;
    end
    req_valid = '0;
    drain();

    // Reset while an operation is in flight
    do_reset();
    set_req(4'b0010);
    @(negedge clk);
    chk(req_ready == 4'b0010, "pre_reset_grant", (W+1)'(req_ready), (W+1)'(4'b0010));
    @(posedge clk); #1;
    rst = 1'b1;
    set_req(4'b1010);
    @(negedge clk);
    chk(idle == 1'b1, "idle_in_reset", (W+1)'(idle), 1);
    chk(req_ready == '0, "ready_in_reset", (W+1)'(req_ready), '0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk(req_ready == 4'b0010, "post_reset_grant", (W+1)'(req_ready), (W+1)'(4'b0010));
    push(1, ts[1], tco[1]);
    @(posedge clk); #1;
    req_valid = '0;
    drain();

    // Random traffic on all requesters
    do_reset();
    for (int c = 0; c < 200; c++) begin
      for (int i = 0; i < N; i++) begin
        req_valid[i]    = ($urandom_range(0, 3) != 0);
        req_a[i*W +: W] = {$urandom, $urandom};
        req_b[i*W +: W] = {$urandom, $urandom};
        req_cin[i]      = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      chk(((req_ready & ~req_valid) == '0) && $onehot0(req_ready), "ready_legal",
          (W+1)'(req_ready), (W+1)'(req_valid));
      for (int i = 0; i < N; i++) begin
        if (req_ready[i]) begin
          rsum = {1'b0, req_a[i*W +: W]} + {1'b0, req_b[i*W +: W]} + (W+1)'(req_cin[i]);
          push(i, rsum[W-1:0], rsum[W]);
        end
      end
      @(posedge clk); #1;
    end
    req_valid = '0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_adder_arbiter.md
PIPELINE_ADDER_ARBITER -- requirements
Module: pipeline_adder_arbiter

Interface
REQ-001 Parameter WIDTH, default 64, adder operand width in bits.
REQ-002 Parameter NREQ, default 4, number of requesters (2..8).
REQ-003 Parameter LATENCY, default 2, clock edges from adder operand presentation to valid add_sum/add_cout.
REQ-004 Parameter MAX_OUT, default 2, maximum in-flight operations per requester (1..LATENCY+1).
REQ-005 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 rst  input  1  asynchronous active-high reset.
REQ-008 req_valid  input  NREQ  per-requester operation request.
REQ-009 req_a, req_b  input  NREQ*WIDTH each  operands; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-010 req_cin  input  NREQ  per-requester carry-in.
REQ-011 req_ready  output  NREQ  one-hot grant; request i accepted in the cycle req_valid[i] && req_ready[i].
REQ-012 add_a, add_b  output  WIDTH each  operands to the shared pipelined adder.
REQ-013 add_cin  output  1  carry-in to the shared adder.
REQ-014 add_sum  input  WIDTH; add_cout  input  1  adder result, valid LATENCY edges after operands.
REQ-015 rsp_valid  output  NREQ  one-hot result strobe, requester i.
REQ-016 rsp_sum  output  WIDTH; rsp_cout  output  1  result returned with rsp_valid.
REQ-017 idle  output  1  high when no operation is in flight.

Function
REQ-018 Eligible[i] SHALL be req_valid[i] && outstanding[i] < MAX_OUT, using registered count only (a same-cycle response does not free a slot).
REQ-019 At most one grant per cycle, chosen round-robin: search starts at pointer ptr, wraps NREQ-1 -> 0.
REQ-020 After a grant to i, ptr SHALL become (i+1) mod NREQ on the next edge; with no grant ptr holds.
REQ-021 req_ready SHALL be combinational from eligibility and ptr; req_ready[i] never asserted without req_valid[i].
REQ-022 In a grant cycle add_a/add_b/add_cin SHALL equal the granted requester's operands; otherwise all zero.
REQ-023 A tag pipeline of LATENCY stages (valid bit + requester index) SHALL shift every cycle; stage 0 loads grant valid/index.
REQ-024 When the last tag stage is valid with index k: rsp_valid = one-hot(k), rsp_sum = add_sum, rsp_cout = add_cout, in the cycle exactly LATENCY cycles after the grant cycle.
REQ-025 When the last tag stage is invalid: rsp_valid = 0, rsp_sum = 0, rsp_cout = 0.
REQ-026 outstanding[i] SHALL increment on grant to i, decrement on response to i, hold when both or neither occur; never exceeds MAX_OUT or goes below 0.
REQ-027 Sustained throughput SHALL be one operation per cycle when enough requesters are eligible; there is no backpressure on responses.
REQ-028 idle SHALL be high iff all tag stages invalid and all outstanding counts zero.
REQ-029 Results return in grant order; per-requester ordering is preserved.

Reset
REQ-030 On rst assertion, immediately: ptr = 0, all tag stages invalid, all outstanding = 0, so rsp_valid = 0 and idle = 1.
REQ-031 Operations in flight at reset SHALL be discarded; no rsp_valid for them after rst deasserts.
REQ-032 req_ready SHALL be 0 while rst is high.

Verification
REQ-033 Single op: req 0, a=0xFFFF_FFFF_FFFF_FFFF, b=1, cin=0 -> grant cycle t, rsp_valid=0001 at t+2, rsp_sum=0, rsp_cout=1.
REQ-034 All four requesters valid continuously -> grants 0,1,2,3,0,... one per cycle, responses in same order 2 cycles later.
REQ-035 Requester 2 alone valid continuously, MAX_OUT=2, LATENCY=2 -> grant pattern granted, granted, blocked, repeating; outstanding[2] never exceeds 2.
REQ-036 rst asserted one cycle after grant to requester 1 -> no rsp_valid ever for that op, idle=1 during reset, first post-reset grant goes to lowest-index valid requester.
REQ-037 Random stimulus, all requesters, random operands/cin -> every rsp_sum/rsp_cout matches a+b+cin of the matching request, per-requester order preserved, idle=1 after drain.
